// File: rtl/seq_nbit_adder_pkg.sv
// Shared definitions for the sequential N-bit adder/subtractor.
package seq_nbit_adder_pkg;

  // Controller state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A configuration is usable only if the operand splits into whole chunks
  function automatic bit legal_cfg(int unsigned width, int unsigned chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_nbit_adder_full_adder.sv
// Single-bit full adder cell; chained CHUNK times to form the per-cycle ripple.
module seq_nbit_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_nbit_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, with carry,
// signed overflow and a one-cycle done pulse.
module seq_nbit_adder
  import seq_nbit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (!legal_cfg(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_nbit_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cy;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_z;
  logic             r_carry;
  logic             r_ovf;

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum;
  logic [WIDTH-1:0] w_z_next;
  logic             w_last;

  // Ripple chain for the current chunk; carry-in is the registered chunk carry
  assign w_c[0] = r_cy;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    seq_nbit_adder_full_adder u_fa (
      .a    (r_a[i]),
      .b    (r_b[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  // Chunk sums enter at the MSB end so z is LSB-aligned after N shifts
  if (CHUNK == WIDTH) begin : g_z_whole
    assign w_z_next = w_sum;
  end else begin : g_z_shift
    assign w_z_next = {w_sum, r_z[WIDTH-1:CHUNK]};
  end

  assign w_last = (r_cnt == LastCnt);

  // Controller and datapath state; sync reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtraction is x + ~y + 1: invert b and seed the carry with sub
            r_a     <= x;
            r_b     <= sub ? ~y : y;
            r_cy    <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_cy  <= w_c[CHUNK];
          r_z   <= w_z_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Final chunk holds the MSB cell: capture carry-out and overflow
            r_carry <= w_c[CHUNK];
            r_ovf   <= w_c[CHUNK] ^ w_c[CHUNK-1];
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign z        = r_z;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_nbit_adder.sv
// Self-checking bench: table-driven vectors on an 8-bit/2-bit-chunk instance,
// multi-cycle corner sequences, and an exhaustive sweep on a 4-bit/4-bit-chunk
// instance. Results are checked through per-instance scoreboard queues.
module tb_seq_nbit_adder;

  typedef struct packed {
    logic [7:0] z;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic       c;
    logic       v;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, 2 bits per cycle (N = 4)
  logic       reset8, start8, sub8;
  logic [7:0] x8, y8, z8;
  logic       carry8, ovf8, busy8, done8;

  // 4-bit, 4 bits per cycle (N = 1)
  logic       reset4, start4, sub4;
  logic [3:0] x4, y4, z4;
  logic       carry4, ovf4, busy4, done4;

  seq_nbit_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk      (clk),
    .reset    (reset8),
    .start    (start8),
    .sub      (sub8),
    .x        (x8),
    .y        (y8),
    .z        (z8),
    .carry    (carry8),
    .overflow (ovf8),
    .busy     (busy8),
    .done     (done8)
  );

  seq_nbit_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset4),
    .start    (start4),
    .sub      (sub4),
    .x        (x4),
    .y        (y4),
    .z        (z4),
    .carry    (carry4),
    .overflow (ovf4),
    .busy     (busy4),
    .done     (done4)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb8[$];
  exp_t sb4[$];

  function automatic void check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Golden model: modulo-2^w add/sub with unsigned carry and signed overflow
  function automatic exp_t model(int unsigned w, logic s, logic [7:0] a, logic [7:0] b);
    exp_t        r;
    int unsigned mask, av, bv, t, zv, sa, sbit, sz;
    mask = (32'd1 << w) - 32'd1;
    av   = 32'(a) & mask;
    bv   = (s ? ~32'(b) : 32'(b)) & mask;
    t    = av + bv + 32'(s);
    zv   = t & mask;
    sa   = (av >> (w - 1)) & 32'd1;
    sbit = (bv >> (w - 1)) & 32'd1;
    sz   = (zv >> (w - 1)) & 32'd1;
    r.z  = 8'(zv);
    r.c  = ((t >> w) & 32'd1) != 0;
    r.v  = (sa == sbit) && (sz != sa);
    return r;
  endfunction

  // Scoreboard consumers: every done must match the oldest pending expectation
  always @(posedge clk) begin : mon8
    exp_t e;
    #1;
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        check("dut8_unexpected_done", int'(done8), 0);
      end else begin
        e = sb8.pop_front();
        check("dut8_z", int'(z8), int'(e.z));
        check("dut8_carry", int'(carry8), int'(e.c));
        check("dut8_overflow", int'(ovf8), int'(e.v));
      end
    end
  end

  always @(posedge clk) begin : mon4
    exp_t e;
    #1;
    if (done4 === 1'b1) begin
      if (sb4.size() == 0) begin
        check("dut4_unexpected_done", int'(done4), 0);
      end else begin
        e = sb4.pop_front();
        check("dut4_z", int'(z4), int'(e.z[3:0]));
        check("dut4_carry", int'(carry4), int'(e.c));
        check("dut4_overflow", int'(ovf4), int'(e.v));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 8-bit instance; returns in the done cycle.
  // glitch_at >= 0 re-pulses start with other operands that many cycles into RUN.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input exp_t e, input int glitch_at);
    int lat;
    int nbusy;
    sub8   = s;
    x8     = a;
    y8     = b;
    start8 = 1'b1;
    sb8.push_back(e);
    tick();
    start8 = 1'b0;
    check("dut8_done_falls_on_start", int'(done8), 0);
    lat   = 0;
    nbusy = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8) nbusy++;
      start8 = (lat == glitch_at);
      if (lat == glitch_at) begin
        sub8 = 1'b1;
        x8   = 8'hFF;
        y8   = 8'hFF;
      end
      tick();
      lat++;
    end
    start8 = 1'b0;
    check("dut8_latency", lat, 4);
    check("dut8_busy_cycles", nbusy, 4);
    check("dut8_busy_low_at_done", int'(busy8), 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'd5,   8'd7,   8'hFE,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'd7,   8'd5,   8'd2,   1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'd127, 8'd1,   8'h80,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80,  8'd1,   8'h7F,  1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'hFF,  8'd1,   8'h00,  1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'd0,   8'd1,   8'hFF,  1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h80,  8'h80,  8'h00,  1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h7F,  8'hFF,  8'h80,  1'b0, 1'b1};

    reset8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; x8 = '0; y8 = '0;
    reset4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; x4 = '0; y4 = '0;
    tick();
    tick();
    reset8 = 1'b0;
    reset4 = 1'b0;

    check("rst8_z", int'(z8), 0);
    check("rst8_carry", int'(carry8), 0);
    check("rst8_overflow", int'(ovf8), 0);
    check("rst8_busy", int'(busy8), 0);
    check("rst8_done", int'(done8), 0);
    check("rst4_z", int'(z4), 0);
    check("rst4_busy", int'(busy4), 0);
    check("rst4_done", int'(done4), 0);

    // Table vectors, each followed by an idle cycle
    for (int i = 0; i < 9; i++) begin
      op8(vecs[i].s, vecs[i].a, vecs[i].b, '{vecs[i].z, vecs[i].c, vecs[i].v}, -1);
      tick();
      check("dut8_done_one_cycle", int'(done8), 0);
      check("dut8_z_held_in_idle", int'(z8), int'(vecs[i].z));
      check("dut8_carry_held_in_idle", int'(carry8), int'(vecs[i].c));
    end

    // start mid-RUN is ignored, then start in the done cycle runs back-to-back
    op8(1'b0, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0}, 1);
    op8(1'b0, 8'd3, 8'd3, '{8'd6, 1'b0, 1'b0}, -1);
    tick();
    check("dut8_b2b_done_one_cycle", int'(done8), 0);

    // Reset during the second RUN cycle discards the operation
    sub8 = 1'b0; x8 = 8'd9; y8 = 8'd9; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    sb8.delete();
    check("midrun_rst_busy", int'(busy8), 0);
    check("midrun_rst_done", int'(done8), 0);
    check("midrun_rst_z", int'(z8), 0);
    check("midrun_rst_carry", int'(carry8), 0);
    check("midrun_rst_overflow", int'(ovf8), 0);
    for (int i = 0; i < 6; i++) tick();
    op8(1'b0, 8'd10, 8'd20, '{8'd30, 1'b0, 1'b0}, -1);
    tick();

    // reset and start on the same edge: reset wins
    reset8 = 1'b1; start8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
    tick();
    reset8 = 1'b0; start8 = 1'b0;
    check("rst_beats_start_busy", int'(busy8), 0);
    tick();
    check("rst_beats_start_still_idle", int'(busy8), 0);

    // Exhaustive 4-bit sweep, single-cycle operation, issued back-to-back
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sub4   = s[0];
          x4     = a[3:0];
          y4     = b[3:0];
          start4 = 1'b1;
          sb4.push_back(model(4, s[0], 8'(a), 8'(b)));
          tick();
          check("dut4_busy_after_start", int'(busy4), 1);
          start4 = 1'b0;
          tick();
          check("dut4_done_after_one", int'(done4), 1);
        end
      end
    end
    start4 = 1'b0;

    for (int i = 0; i < 4; i++) tick();
    check("dut8_scoreboard_drained", sb8.size(), 0);
    check("dut4_scoreboard_drained", sb4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_nbit_adder.md
# seq_nbit_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's 2-bit combinational adder. It latches two WIDTH-bit operands on a start pulse, then computes CHUNK bits per clock, LSB first, through a ripple of full-adder cells. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the arithmetic unit for later lab datapaths that trade latency for area.

## Interface
- WIDTH, default 8: operand and result width; must be ≥ 2.
- CHUNK, default 2: bits processed per cycle; WIDTH % CHUNK == 0; N = WIDTH/CHUNK cycles per operation.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; one clock; sampled on rising clk only.
- start  in  1  request; sampled only when state is IDLE or DONE.
- sub  in  1  0 = x + y, 1 = x − y; sampled with start.
- x  in  WIDTH  operand A; sampled with start.
- y  in  WIDTH  operand B; sampled with start.
- z  out  WIDTH  result register.
- carry  out  1  carry out of MSB; for sub, 1 means no borrow (x ≥ y unsigned).
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse when results become valid.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after N chunk cycles.
  - DONE → RUN on start; otherwise DONE → IDLE.
- On an accepted start, latch x into register a, and latch (sub ? ~y : y) into register b. Set the internal carry to sub. Clear chunk counter cnt to 0.
- Each RUN cycle:
  - Add a[CHUNK-1:0] + b[CHUNK-1:0] + carry through CHUNK chained full adders.
  - Shift a and b right by CHUNK.
  - Shift the CHUNK sum bits into z from the MSB end, so z is LSB-aligned after N shifts.
  - Register the chunk carry-out.
  - Increment cnt.
- On the final chunk, capture the carry into the MSB cell for the overflow calculation. carry and overflow are updated only on the RUN → DONE edge.
- start is ignored while in RUN; operands and sub are then don't-care.
- z, carry and overflow hold their values from DONE onward until the next accepted start's first RUN edge. They are not cleared on return to IDLE.
- Arithmetic is modulo 2^WIDTH; z is never widened.

## Timing
- Reset values: state IDLE, z = 0, carry = 0, overflow = 0, busy = 0, done = 0, cnt = 0.
- start sampled high at edge k:
  - busy is 1 for cycles k+1 … k+N.
  - done is 1 for exactly the cycle after edge k+N.
  - Latency from start to done is N cycles.
- Back-to-back operation: start high while done = 1 is accepted. busy rises on the next edge, and done falls on that same edge.
- reset asserted at any edge, including mid-RUN: the next state is IDLE with all outputs at reset values. The in-flight operation is discarded and no done is produced.
- reset and start high on the same edge: reset wins.
- CHUNK = WIDTH: N = 1, so done follows start by one cycle.

## Structure
- Shared header adder_defs.vh holds:
  - State encodings S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - The WIDTH % CHUNK legality check macro.
- One sub-module, full_adder (a, b, cin → s, cout), generated CHUNK times per chunk in a ripple chain.
- cnt width is $clog2(N) + 1.

## Test plan
- WIDTH = 8, CHUNK = 2, add 200 + 100 → z = 44, carry = 1, overflow = 0; done exactly 4 cycles after start; busy high for 4 cycles.
- Subtract 5 − 7 → z = 8'hFE, carry = 0, overflow = 0. Subtract 7 − 5 → z = 2, carry = 1.
- Add 127 + 1 → z = 8'h80, carry = 0, overflow = 1. Subtract 8'h80 − 1 → z = 8'h7F, overflow = 1.
- Pulse start again mid-RUN with different operands → ignored; the original result is delivered. Then start during the done cycle (3 + 3) → accepted; z = 6 four cycles later with no idle gap.
- Assert reset at the second RUN cycle → busy = 0, done never pulses, z/carry/overflow = 0. Next start → correct result.
- WIDTH = 4, CHUNK = 4, sweep all 256 add and 256 sub cases → every result matches the golden model, with done one cycle after start.
